// File: rtl/mmio_router.sv
// Single-outstanding router from the core bus to a sync-read RAM or one of
// NUM_DEV peripheral windows, with variable device latency and a per-access timeout.
module mmio_router #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                NUM_DEV  = 4,
    parameter logic [ADDR_W-1:0] DEV_BASE = 'h200,
    parameter int                DEV_SPAN = 16,
    parameter int                TIMEOUT  = 15,
    localparam int               BE_W     = DATA_W / 8,
    localparam int               OFF_W    = $clog2(DEV_SPAN)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_we,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [BE_W-1:0]           req_be,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic [BE_W-1:0]           ram_be,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_q,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic                      dev_we,
    output logic [OFF_W-1:0]          dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    output logic [BE_W-1:0]           dev_be,
    input  logic [NUM_DEV-1:0]        dev_ack,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata
);

    localparam int SLOT_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    if (NUM_DEV < 1 || NUM_DEV > 16) begin : g_bad_num_dev
        $error("mmio_router: NUM_DEV must be in 1..16");
    end
    if (DEV_SPAN < 4 || (DEV_SPAN & (DEV_SPAN - 1)) != 0) begin : g_bad_span
        $error("mmio_router: DEV_SPAN must be a power of two >= 4");
    end
    if (DEV_BASE[OFF_W-1:0] != '0) begin : g_bad_base
        $error("mmio_router: DEV_BASE must be DEV_SPAN-aligned");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mmio_router: TIMEOUT must be >= 1");
    end

    // One extra bit so the window end never wraps around the address space.
    localparam logic [ADDR_W:0] BASE_X = {1'b0, DEV_BASE};
    localparam logic [ADDR_W:0] WIN_X  = (ADDR_W + 1)'(NUM_DEV) << OFF_W;

    typedef enum logic [2:0] {IDLE, RAM_ISSUE, RAM_DATA, DEV_WAIT, RSP} state_t;

    state_t             state;
    logic               wr;
    logic [SLOT_W-1:0]  slot;
    logic [CNT_W-1:0]   cnt;

    logic [ADDR_W:0]    addr_x;
    logic [ADDR_W:0]    off_x;
    logic               dev_hit;
    logic [SLOT_W-1:0]  hit_slot;
    logic [NUM_DEV-1:0] hit_sel;
    logic [DATA_W-1:0]  sel_rdata;
    logic               ack_hit;

    always_comb begin
        addr_x    = {1'b0, req_addr};
        off_x     = addr_x - BASE_X;
        dev_hit   = (addr_x >= BASE_X) && (off_x < WIN_X);
        hit_slot  = off_x[OFF_W +: SLOT_W];
        hit_sel   = NUM_DEV'(1) << hit_slot;
        sel_rdata = dev_rdata[slot*DATA_W +: DATA_W];
        ack_hit   = |(dev_ack & dev_sel);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
            ram_we    <= 1'b0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev_be    <= '0;
            wr        <= 1'b0;
            slot      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        wr        <= req_we;
                        if (dev_hit) begin
                            dev_sel   <= hit_sel;
                            dev_we    <= req_we;
                            dev_addr  <= req_addr[OFF_W-1:0];
                            dev_wdata <= req_wdata;
                            dev_be    <= req_be;
                            slot      <= hit_slot;
                            cnt       <= '0;
                            state     <= DEV_WAIT;
                        end else begin
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata;
                            ram_be    <= req_be;
                            ram_we    <= req_we;
                            state     <= RAM_ISSUE;
                        end
                    end
                end
                RAM_ISSUE: begin
                    ram_we <= 1'b0;
                    ram_be <= '0;
                    state  <= RAM_DATA;
                end
                RAM_DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= wr ? '0 : ram_q;
                    state     <= RSP;
                end
                DEV_WAIT: begin
                    // An ack on the final allowed edge takes priority over the timeout.
                    if (ack_hit) begin
                        dev_sel   <= '0;
                        dev_we    <= 1'b0;
                        dev_be    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wr ? '0 : sel_rdata;
                        state     <= RSP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        dev_sel   <= '0;
                        dev_we    <= 1'b0;
                        dev_be    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RSP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: responses are predicted into a queue when a
// request is driven and checked by a monitor when rsp_valid pulses.
module tb_mmio_router;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic [3:0]   req_be;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic [3:0]   ram_be;
    logic         ram_we;
    logic [31:0]  ram_q;
    logic [3:0]   dev_sel;
    logic         dev_we;
    logic [3:0]   dev_addr;
    logic [31:0]  dev_wdata;
    logic [3:0]   dev_be;
    logic [3:0]   dev_ack;
    logic [127:0] dev_rdata;

    mmio_router dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_q(ram_q),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_be(dev_be), .dev_ack(dev_ack),
        .dev_rdata(dev_rdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every response pulse must match the oldest prediction.
    always @(negedge clock) begin
        rsp_t e;
        if (rsp_valid) begin
            chk("rsp_one_cycle", {63'd0, prev_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end else if (rsp_err) begin
            chk("rsp_err_without_valid", {63'd0, rsp_err}, 64'd0);
        end
        prev_valid = rsp_valid;
    end

    // Drives one request at the current falling edge; returns one cycle after acceptance.
    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        chk("ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = d;
        req_be    = be;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_be    = '0;
        ram_q     = '0;
        dev_ack   = '0;
        dev_rdata = {32'h3333_3333, 32'h2222_2222, 32'h0000_00A5, 32'h1111_0000};

        repeat (3) @(negedge clock);
        chk("reset_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_dev_sel", {60'd0, dev_sel}, 64'd0);
        chk("reset_ram_we", {63'd0, ram_we}, 64'd0);
        chk("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // RAM read 0x40
        ram_q = 32'hDEAD_BEEF;
        issue(32'h40, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        chk("rd_ram_addr", {32'd0, ram_addr}, 64'h40);
        chk("rd_ram_we", {63'd0, ram_we}, 64'd0);
        chk("rd_ready_c1", {63'd0, req_ready}, 64'd0);
        chk("rd_dev_sel", {60'd0, dev_sel}, 64'd0);
        @(negedge clock);
        chk("rd_ready_c2", {63'd0, req_ready}, 64'd0);
        chk("rd_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
        @(negedge clock);
        chk("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd_ready_c3", {63'd0, req_ready}, 64'd0);
        @(negedge clock);
        chk("rd_rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("rd_ready_back", {63'd0, req_ready}, 64'd1);
        chk("rd_rdata_hold", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);

        // RAM write 0x44, partial byte enables
        ram_q = 32'hFFFF_FFFF;
        issue(32'h44, 1'b1, 32'h1234, 4'b0011, 32'h0, 1'b0);
        chk("wr_ram_we", {63'd0, ram_we}, 64'd1);
        chk("wr_ram_be", {60'd0, ram_be}, 64'h3);
        chk("wr_ram_wdata", {32'd0, ram_wdata}, 64'h1234);
        chk("wr_ram_addr", {32'd0, ram_addr}, 64'h44);
        @(negedge clock);
        chk("wr_ram_we_off", {63'd0, ram_we}, 64'd0);
        chk("wr_ram_be_off", {60'd0, ram_be}, 64'd0);
        @(negedge clock);
        chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(negedge clock);
        chk("wr_ready_back", {63'd0, req_ready}, 64'd1);

        // Slot 1 read 0x214, ack on the third edge after acceptance
        issue(32'h214, 1'b0, 32'h0, 4'hF, 32'h0000_00A5, 1'b0);
        chk("s1_dev_sel", {60'd0, dev_sel}, 64'h2);
        chk("s1_dev_addr", {60'd0, dev_addr}, 64'h4);
        chk("s1_dev_we", {63'd0, dev_we}, 64'd0);
        chk("s1_ram_we", {63'd0, ram_we}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        chk("s1_sel_waiting", {60'd0, dev_sel}, 64'h2);
        dev_ack = 4'b0010;
        @(negedge clock);
        dev_ack = 4'b0000;
        chk("s1_sel_cleared", {60'd0, dev_sel}, 64'h0);
        chk("s1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(negedge clock);
        chk("s1_ready_back", {63'd0, req_ready}, 64'd1);

        // Slot 3 write 0x230, never acked: timeout on the 15th edge
        issue(32'h230, 1'b1, 32'hCAFE_0001, 4'b1111, 32'h0, 1'b1);
        chk("s3_dev_we", {63'd0, dev_we}, 64'd1);
        chk("s3_dev_wdata", {32'd0, dev_wdata}, 64'hCAFE_0001);
        for (int i = 0; i < 15; i++) begin
            chk("to_sel_held", {60'd0, dev_sel}, 64'h8);
            chk("to_no_rsp", {63'd0, rsp_valid}, 64'd0);
            @(negedge clock);
        end
        chk("to_sel_cleared", {60'd0, dev_sel}, 64'h0);
        chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("to_rsp_err", {63'd0, rsp_err}, 64'd1);
        @(negedge clock);
        chk("to_err_drop", {63'd0, rsp_err}, 64'd0);

        // Slot 3 read with ack sampled exactly on the 15th edge: ack wins
        issue(32'h230, 1'b0, 32'h0, 4'hF, 32'h3333_3333, 1'b0);
        for (int i = 0; i < 15; i++) begin
            chk("ack15_sel_held", {60'd0, dev_sel}, 64'h8);
            if (i == 14) dev_ack = 4'b1000;
            @(negedge clock);
        end
        dev_ack = 4'b0000;
        chk("ack15_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("ack15_rsp_err", {63'd0, rsp_err}, 64'd0);
        @(negedge clock);

        // 0x240 lies past the last slot and must go to RAM
        ram_q = 32'h0BAD_F00D;
        issue(32'h240, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
        chk("past_dev_sel", {60'd0, dev_sel}, 64'h0);
        chk("past_ram_addr", {32'd0, ram_addr}, 64'h240);
        repeat (3) @(negedge clock);
        chk("past_ready_back", {63'd0, req_ready}, 64'd1);

        // 0x1FC sits just below the first slot
        ram_q = 32'h1357_9BDF;
        issue(32'h1FC, 1'b0, 32'h0, 4'hF, 32'h1357_9BDF, 1'b0);
        chk("below_dev_sel", {60'd0, dev_sel}, 64'h0);
        repeat (3) @(negedge clock);

        // Slot 2 read with a stray ack from slot 0 throughout; real ack on edge 2
        dev_ack = 4'b0001;
        issue(32'h228, 1'b0, 32'h0, 4'b0000, 32'h2222_2222, 1'b0);
        chk("s2_dev_sel", {60'd0, dev_sel}, 64'h4);
        chk("s2_dev_addr", {60'd0, dev_addr}, 64'h8);
        chk("s2_dev_be_zero", {60'd0, dev_be}, 64'h0);
        @(negedge clock);
        chk("s2_stray_ignored", {60'd0, dev_sel}, 64'h4);
        chk("s2_stray_no_rsp", {63'd0, rsp_valid}, 64'd0);
        dev_ack = 4'b0101;
        @(negedge clock);
        dev_ack = 4'b0000;
        chk("s2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(negedge clock);

        // Reset in the middle of a slot-0 wait: drop the access immediately
        issue(32'h200, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        chk("mid_dev_sel", {60'd0, dev_sel}, 64'h1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dev_sel", {60'd0, dev_sel}, 64'h0);
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("mid_rst_still_idle", {63'd0, req_ready}, 64'd1);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
